imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-port, 1-cycle-latency instruction BRAM between the core fetch path and a
//  program-loader write path (UART/debug download). Grants at most one access per cycle.
//  Tracks the in-flight read and returns it as a valid-qualified instruction.
//  Supports fetch flush (branch redirect) and a loader-starvation guard. Sits between PC logic and the BRAM.
// PARAMETERS
//  INST_DEPTH  256  BRAM depth in 32-bit words; AW = $clog2(INST_DEPTH) (localparam)
//  MAX_LD_RUN  8    max consecutive loader grants while fetch_req is pending (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   synchronous active-low reset
//  fetch_req    in   1   core requests a read of fetch_addr this cycle
//  fetch_addr   in   AW  word address (PC[AW+1:2])
//  fetch_gnt    out  1   fetch read issued to BRAM this cycle
//  fetch_valid  out  1   fetch_inst holds the data for the fetch granted last cycle
//  fetch_inst   out  32  instruction; 0 whenever fetch_valid=0
//  flush        in   1   drop the in-flight read and suppress this cycle's fetch grant
//  ld_req       in   1   loader requests a write
//  ld_addr      in   AW  loader word address
//  ld_data      in   32  loader write data
//  ld_gnt       out  1   write issued to BRAM this cycle
//  mem_addr     out  AW  BRAM address
//  mem_we       out  1   BRAM write enable
//  mem_wdata    out  32  BRAM write data (= ld_data)
//  mem_rdata    in   32  BRAM read data, valid 1 cycle after the read address is presented
//  busy         out  1   state != IDLE or a read is pending
// BEHAVIOUR
//  Clocking and reset
//   - One clock. Reset is synchronous and active-low.
//   - While rst_n=0: fetch_gnt, ld_gnt, mem_we, fetch_valid and busy = 0; fetch_inst = 0.
//   - Reset clears pend, run_cnt and state (IDLE).
//   - A read granted in the cycle reset asserts never yields fetch_valid.
//  Arbitration (combinational, per cycle; rst_n=1)
//   - ld_win = ld_req & (!fetch_req | run_cnt < MAX_LD_RUN)
//   - ld_gnt = ld_win
//   - fetch_gnt = fetch_req & !ld_win & !flush
//   - Grants are mutually exclusive. No grant leaves mem_we=0.
//  BRAM drive
//   - mem_we = ld_gnt
//   - mem_addr = ld_gnt ? ld_addr : fetch_addr
//   - mem_wdata = ld_data
//  Read tracking
//   - pend <= fetch_gnt
//   - fetch_valid = pend & !flush
//   - fetch_inst = fetch_valid ? mem_rdata : 0
//   - Latency: grant at cycle t -> fetch_valid at t+1.
//   - Back-to-back fetches sustain 1 instruction per cycle.
//  Starvation guard
//   - run_cnt (width $clog2(MAX_LD_RUN+1)) increments on ld_gnt & fetch_req, saturating at MAX_LD_RUN.
//   - run_cnt clears to 0 on fetch_gnt or when fetch_req=0.
//   - With both requesting continuously: MAX_LD_RUN writes, then 1 fetch, repeating.
//   - If flush blocks that fetch slot, the slot is idle and run_cnt holds.
//  State (registered last grant): IDLE / FETCH / LOAD
//   - Next state = LOAD on ld_gnt, FETCH on fetch_gnt, else IDLE.
//   - Used only for busy and debug.
//  Boundary cases
//   - Write to A at t, fetch of A at t+1: returns the new data (no same-cycle hazard exists).
//   - Addresses are AW bits wide; no out-of-range case exists.
//   - flush and fetch_req in the same cycle: no grant; the pending read is also dropped.
//   - ld_req with fetch_req=0: loader wins every cycle; run_cnt stays 0.
// TESTING
//  1. Hold rst_n=0 3 cycles with fetch_req=1 -> all grants/valid 0. First cycle after release:
//     fetch_gnt=1; next cycle fetch_valid=1.
//  2. Preload mem[5]=32'h2002_0005; fetch_addr=5 at t -> fetch_gnt=1 at t;
//     fetch_valid=1 and fetch_inst=32'h2002_0005 at t+1.
//  3. Fetch addresses 0,1,2,3 back-to-back -> 4 consecutive fetch_valid, data in order, no bubbles.
//  4. MAX_LD_RUN=8; ld_req and fetch_req both held 20 cycles -> grant pattern 8 ld, 1 fetch,
//     8 ld, 1 fetch, 2 ld.
//  5. Fetch grant at t, flush=1 at t+1 with fetch_req=1 -> fetch_valid=0 and fetch_gnt=0 at t+1;
//     normal fetch resumes at t+2.
//  6. ld write 32'hDEAD_BEEF to addr 9 at t, fetch addr 9 at t+1 -> fetch_inst=32'hDEAD_BEEF at t+2.
//     rst_n=0 at t+1 -> no fetch_valid at t+2.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Single-port instruction BRAM arbiter: shares one read/write port between the
// core fetch path and the program loader, and returns fetched words valid-qualified.
module imem_port_arbiter #(
  parameter  int INST_DEPTH = 256,
  parameter  int MAX_LD_RUN = 8,
  localparam int AW         = $clog2(INST_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_valid,
  output logic [31:0]   fetch_inst,
  input  logic          flush,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          ld_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int            CW      = $clog2(MAX_LD_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_LD_RUN);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD
  } state_t;

  state_t        state;
  logic          pend;
  logic [CW-1:0] run_cnt;
  logic          ld_win;
  logic          fetch_win;

  // The loader normally has priority; once it has held the port MAX_LD_RUN
  // cycles in a row against a waiting fetch, one fetch slot is forced through.
  always_comb begin
    ld_win    = ld_req & (~fetch_req | (run_cnt < RUN_MAX));
    fetch_win = fetch_req & ~ld_win & ~flush;
  end

  // Reset is synchronous, so registers may still hold stale values during the
  // first reset cycle; every output is gated by rst_n to stay quiet throughout.
  assign ld_gnt      = rst_n & ld_win;
  assign fetch_gnt   = rst_n & fetch_win;
  assign mem_we      = ld_gnt;
  assign mem_addr    = ld_gnt ? ld_addr : fetch_addr;
  assign mem_wdata   = ld_data;
  assign fetch_valid = rst_n & pend & ~flush;
  assign fetch_inst  = fetch_valid ? mem_rdata : 32'h0;
  assign busy        = rst_n & ((state != IDLE) | pend);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of this cycle's grants.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      run_cnt <= '0;
      state   <= IDLE;
    end else begin
      pend <= fetch_gnt;

      if (!fetch_req || fetch_gnt) begin
        run_cnt <= '0;
      end else if (ld_gnt && (run_cnt < RUN_MAX)) begin
        run_cnt <= run_cnt + 1'b1;
      end

      if (ld_gnt) begin
        state <= LOAD;
      end else if (fetch_gnt) begin
        state <= FETCH;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 1-cycle BRAM and a
// scoreboard queue of expected fetch results.
module tb_imem_port_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [31:0]   fetch_inst;
  logic          flush;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  bit   [31:0]   mem_rdata;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  bit   [31:0] bram    [256];
  bit   [31:0] exp_mem [256];
  logic [31:0] sb_q    [$];
  bit          prev_any_gnt = 1'b0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.INST_DEPTH(256), .MAX_LD_RUN(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .flush       (flush),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_gnt      (ld_gnt),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  // Behavioural single-port BRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge against
  // the expected grants, then advance past the next rising edge.
  task automatic step(input bit rst, input bit fr, input logic [AW-1:0] fa, input bit fl,
                      input bit lr, input logic [AW-1:0] la, input logic [31:0] ld,
                      input bit efg, input bit elg);
    logic [31:0] item;
    bit          ev;
    rst_n      = rst;
    fetch_req  = fr;
    fetch_addr = fa;
    flush      = fl;
    ld_req     = lr;
    ld_addr    = la;
    ld_data    = ld;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      ev   = rst && !fl;
      check("fetch_valid", {31'b0, fetch_valid}, {31'b0, ev});
      if (ev) check("fetch_inst", fetch_inst, item);
      else    check("fetch_inst_zero", fetch_inst, 32'h0);
    end else begin
      check("fetch_valid_idle", {31'b0, fetch_valid}, 32'h0);
      check("fetch_inst_idle", fetch_inst, 32'h0);
    end
    check("fetch_gnt", {31'b0, fetch_gnt}, {31'b0, efg});
    check("ld_gnt", {31'b0, ld_gnt}, {31'b0, elg});
    check("mem_we", {31'b0, mem_we}, {31'b0, elg});
    check("busy", {31'b0, busy}, {31'b0, rst && prev_any_gnt});
    if (elg) begin
      check("mem_addr_ld", {24'b0, mem_addr}, {24'b0, la});
      check("mem_wdata", mem_wdata, ld);
    end else if (efg) begin
      check("mem_addr_fetch", {24'b0, mem_addr}, {24'b0, fa});
    end
    if (efg) sb_q.push_back(exp_mem[fa]);
    if (elg) exp_mem[la] = ld;
    prev_any_gnt = efg | elg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_data = '0;
    @(posedge clk);
    #1;

    // Reset held 3 cycles with fetch requested: nothing granted or valid.
    for (int i = 0; i < 3; i++) step(0, 1, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);
    // First cycle out of reset fetches, next cycle returns it.
    step(1, 1, 8'd0, 0, 0, 8'd0, 32'h0, 1, 0);

    // Preload through the loader with no fetch pending: loader wins each cycle.
    for (int i = 0; i < 16; i++)
      step(1, 0, 8'd0, 0, 1, 8'(i), 32'h2002_0000 + 32'(i), 0, 1);

    // Both requesting 20 cycles: 8 ld, 1 fetch, 8 ld, 1 fetch, 2 ld.
    for (int i = 0; i < 20; i++)
      step(1, 1, 8'd3, 0, 1, 8'(100 + i), 32'hA000_0000 + 32'(i),
           (i == 8 || i == 17), !(i == 8 || i == 17));
    step(1, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);

    // Single fetch of preloaded word 5.
    step(1, 1, 8'd5, 0, 0, 8'd0, 32'h0, 1, 0);
    step(1, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);

    // Back-to-back fetches of 0..3, then one idle cycle for the last return.
    for (int i = 0; i < 4; i++) step(1, 1, 8'(i), 0, 0, 8'd0, 32'h0, 1, 0);
    step(1, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);

    // Flush cancels the in-flight read and the same-cycle grant; fetch resumes after.
    step(1, 1, 8'd6, 0, 0, 8'd0, 32'h0, 1, 0);
    step(1, 1, 8'd7, 1, 0, 8'd0, 32'h0, 0, 0);
    step(1, 1, 8'd8, 0, 0, 8'd0, 32'h0, 1, 0);
    step(1, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);

    // Flush blocking the forced fetch slot leaves it idle; the slot is retried.
    for (int i = 0; i < 8; i++)
      step(1, 1, 8'd2, 0, 1, 8'(200 + i), 32'hB000_0000 + 32'(i), 0, 1);
    step(1, 1, 8'd2, 1, 1, 8'd210, 32'hB0B0_B0B0, 0, 0);
    step(1, 1, 8'd2, 0, 1, 8'd211, 32'hB1B1_B1B1, 1, 0);
    step(1, 1, 8'd2, 0, 1, 8'd212, 32'hB2B2_B2B2, 0, 1);
    step(1, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);

    // Write then immediate read of the same address returns the new word.
    step(1, 0, 8'd0, 0, 1, 8'd9, 32'hDEAD_BEEF, 0, 1);
    step(1, 1, 8'd9, 0, 0, 8'd0, 32'h0, 1, 0);
    step(1, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);

    // Reset in the fetch cycle: no grant and no valid afterwards.
    step(1, 0, 8'd0, 0, 1, 8'd9, 32'hCAFE_F00D, 0, 1);
    step(0, 1, 8'd9, 0, 0, 8'd0, 32'h0, 0, 0);
    step(1, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);
    step(1, 1, 8'd9, 0, 0, 8'd0, 32'h0, 1, 0);
    step(1, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);

    // Reset arriving while a read is in flight drops it.
    step(1, 1, 8'd4, 0, 0, 8'd0, 32'h0, 1, 0);
    step(0, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);
    step(1, 0, 8'd0, 0, 0, 8'd0, 32'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
